// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALUSrc mux, ALU, iterative shift-add MUL, EX/MEM register.
// Optional macro EX_MUL_EN adds the multi-cycle MUL unit and its upstream stall.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [1:0]      WB_i,
    input  logic            MEM_i,
    input  logic            ALUSrc_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] RS1_i,
    input  logic [XLEN-1:0] RS2_i,
    input  logic [XLEN-1:0] IMM_i,
    input  logic [4:0]      RS1addr_i,
    input  logic [4:0]      RS2addr_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            EXMEM_RegWrite_i,
    input  logic            MEMWB_RegWrite_i,
    input  logic [4:0]      EXMEM_RDaddr_i,
    input  logic [4:0]      MEMWB_RDaddr_i,
    input  logic [XLEN-1:0] EXMEM_data_i,
    input  logic [XLEN-1:0] MEMWB_data_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [1:0]      WB_o,
    output logic            MEM_o,
    output logic [XLEN-1:0] ALUResult_o,
    output logic [XLEN-1:0] RS2data_o,
    output logic [4:0]      RDaddr_o
);

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res;
    logic            take_alu;

    // The younger producer (EX/MEM) wins when both stages target the same register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op_a  = RS1_i;
        fwd_b = RS2_i;
        if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS1addr_i) op_a  = MEMWB_data_i;
        if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS1addr_i) op_a  = EXMEM_data_i;
        if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS2addr_i) fwd_b = MEMWB_data_i;
        if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == RS2addr_i) fwd_b = EXMEM_data_i;
    end

    assign op_b = ALUSrc_i ? IMM_i : fwd_b;

`ifdef EX_MUL_EN
    logic is_mul;
`endif

    always_comb begin
        alu_res = '0;
`ifdef EX_MUL_EN
        is_mul  = 1'b0;
`endif
        case (ALUOp_i)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (funct_i)
                    10'b0000000_000: alu_res = op_a + op_b;
                    10'b0100000_000: alu_res = op_a - op_b;
                    10'b0000000_111: alu_res = op_a & op_b;
                    10'b0000000_110: alu_res = op_a | op_b;
                    10'b0000000_100: alu_res = op_a ^ op_b;
                    10'b0000000_001: alu_res = op_a << op_b[4:0];
`ifdef EX_MUL_EN
                    10'b0000001_000: is_mul = 1'b1;
`endif
                    default:         alu_res = '0;
                endcase
            end
            default: begin
                case (funct_i[2:0])
                    3'b000:  alu_res = op_a + op_b;
                    3'b111:  alu_res = op_a & op_b;
                    3'b110:  alu_res = op_a | op_b;
                    3'b101:  if (funct_i[9:3] == 7'b0100000) alu_res = $signed(op_a) >>> IMM_i[4:0];
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mul_a_q, mul_b_q, acc_q, rs2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      wb_q;
    logic            mem_q;
    logic [4:0]      rd_q;
    logic            mul_start, mul_busy, mul_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i && is_mul) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state_q == S_IDLE) && valid_i && is_mul;
        mul_busy  = (state_q == S_BUSY);
        mul_done  = (state_q == S_DONE);
        stall_o   = (mul_start || mul_busy) && !rst_i;
    end

    // Operands and control are captured at start so draining forwarding sources cannot disturb the product.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst_i) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            rs2_q   <= '0;
            cnt_q   <= '0;
            wb_q    <= '0;
            mem_q   <= 1'b0;
            rd_q    <= '0;
        end else if (mul_start) begin
            mul_a_q <= op_a;
            mul_b_q <= op_b;
            acc_q   <= '0;
            rs2_q   <= fwd_b;
            cnt_q   <= '0;
            wb_q    <= WB_i;
            mem_q   <= MEM_i;
            rd_q    <= RDaddr_i;
        end else if (mul_busy) begin
            acc_q   <= acc_q + (mul_b_q[0] ? mul_a_q : '0);
            mul_a_q <= mul_a_q << 1;
            mul_b_q <= mul_b_q >> 1;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign take_alu = valid_i && !mul_start && !mul_busy && !mul_done;
`else
    assign stall_o  = 1'b0;
    assign take_alu = valid_i;
`endif

    logic            valid_d, mem_d;
    logic [1:0]      wb_d;
    logic [XLEN-1:0] res_d, rs2_d;
    logic [4:0]      rd_d;

    // Anything not explicitly selected below registers as a bubble.
    always_comb begin
        valid_d = 1'b0;
        wb_d    = '0;
        mem_d   = 1'b0;
        res_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        if (take_alu) begin
            valid_d = 1'b1;
            wb_d    = WB_i;
            mem_d   = MEM_i;
            res_d   = alu_res;
            rs2_d   = fwd_b;
            rd_d    = RDaddr_i;
        end
`ifdef EX_MUL_EN
        if (mul_done) begin
            valid_d = 1'b1;
            wb_d    = wb_q;
            mem_d   = mem_q;
            res_d   = acc_q;
            rs2_d   = rs2_q;
            rd_d    = rd_q;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            WB_o        <= '0;
            MEM_o       <= 1'b0;
            ALUResult_o <= '0;
            RS2data_o   <= '0;
            RDaddr_o    <= '0;
        end else begin
            valid_o     <= valid_d;
            WB_o        <= wb_d;
            MEM_o       <= mem_d;
            ALUResult_o <= res_d;
            RS2data_o   <= rs2_d;
            RDaddr_o    <= rd_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; MUL checks follow the EX_MUL_EN build macro.
module tb_ex_stage;

    localparam logic [9:0] F_ADD  = 10'b0000000_000;
    localparam logic [9:0] F_SUB  = 10'b0100000_000;
    localparam logic [9:0] F_AND  = 10'b0000000_111;
    localparam logic [9:0] F_OR   = 10'b0000000_110;
    localparam logic [9:0] F_XOR  = 10'b0000000_100;
    localparam logic [9:0] F_SLL  = 10'b0000000_001;
    localparam logic [9:0] F_MUL  = 10'b0000001_000;
    localparam logic [9:0] F_SRAI = 10'b0100000_101;

    logic        clk_i, rst_i, valid_i, MEM_i, ALUSrc_i;
    logic [1:0]  WB_i, ALUOp_i;
    logic [9:0]  funct_i;
    logic [31:0] RS1_i, RS2_i, IMM_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
    logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
    logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
    logic [31:0] EXMEM_data_i, MEMWB_data_i;
    logic        stall_o, valid_o, MEM_o;
    logic [1:0]  WB_o;
    logic [31:0] ALUResult_o, RS2data_o;
    logic [4:0]  RDaddr_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .WB_i(WB_i), .MEM_i(MEM_i),
        .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
        .RS1_i(RS1_i), .RS2_i(RS2_i), .IMM_i(IMM_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
        .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i),
        .EXMEM_data_i(EXMEM_data_i), .MEMWB_data_i(MEMWB_data_i),
        .stall_o(stall_o), .valid_o(valid_o), .WB_o(WB_o), .MEM_o(MEM_o),
        .ALUResult_o(ALUResult_o), .RS2data_o(RS2data_o), .RDaddr_o(RDaddr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 1'b0; WB_i = 2'b00; MEM_i = 1'b0; ALUSrc_i = 1'b0;
        ALUOp_i = 2'b00; funct_i = '0;
        RS1_i = '0; RS2_i = '0; IMM_i = '0;
        RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = 5'd10;
        EXMEM_RegWrite_i = 1'b0; MEMWB_RegWrite_i = 1'b0;
        EXMEM_RDaddr_i = '0; MEMWB_RDaddr_i = '0;
        EXMEM_data_i = '0; MEMWB_data_i = '0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [9:0] f, input logic src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        valid_i = 1'b1; WB_i = 2'b10;
        ALUOp_i = op; funct_i = f; ALUSrc_i = src;
        RS1_i = a; RS2_i = b; IMM_i = imm;
    endtask

    task automatic alu(input string tag, input logic [1:0] op, input logic [9:0] f, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] exp);
        drive(op, f, src, a, b, imm);
        tick();
        check(tag, ALUResult_o, exp);
    endtask

`ifdef EX_MUL_EN
    // Issues a MUL and holds it until the result edge; returns with the MUL still on the inputs.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int stalls, bubbles;
        drive(2'b10, F_MUL, 1'b0, a, b, 32'h0);
        RS1addr_i = 5'd1; RS2addr_i = 5'd2; RDaddr_i = 5'd12;
        #1;
        stalls = 0; bubbles = 0;
        for (int k = 0; k < 40 && stall_o; k++) begin
            stalls++;
            if (k == 5) EXMEM_data_i = 32'h1234_5678;
            tick();
            if (!valid_o) bubbles++;
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        check({tag, "_bubble_edges"}, 32'(bubbles), 32'd33);
        check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        tick();
        check({tag, "_result"}, ALUResult_o, exp);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_rd"}, {27'd0, RDaddr_o}, 32'd12);
    endtask
`endif

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        drive(2'b10, F_MUL, 1'b0, 32'd6, 32'd7, 32'd0);
        #1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        tick();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_wb", {30'd0, WB_o}, 32'd0);
        check("rst_mem", {31'd0, MEM_o}, 32'd0);
        check("rst_res", ALUResult_o, 32'd0);
        check("rst_rs2", RS2data_o, 32'd0);
        check("rst_rd", {27'd0, RDaddr_o}, 32'd0);
        check("rst_stall_hold", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b0;
        clear_inputs();
        tick();

        // Plain R-type add with control passthrough
        MEM_i = 1'b1;
        alu("add", 2'b10, F_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12);
        check("add_valid", {31'd0, valid_o}, 32'd1);
        check("add_rd", {27'd0, RDaddr_o}, 32'd10);
        check("add_wb", {30'd0, WB_o}, 32'd2);
        check("add_mem", {31'd0, MEM_o}, 32'd1);
        check("add_rs2", RS2data_o, 32'd7);
        MEM_i = 1'b0;

        // Forwarding priority and the x0 exclusion
        RS1addr_i = 5'd3;
        EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd3; EXMEM_data_i = 32'd100;
        MEMWB_RegWrite_i = 1'b1; MEMWB_RDaddr_i = 5'd3; MEMWB_data_i = 32'd200;
        alu("fwd_exmem", 2'b10, F_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd101);
        EXMEM_RegWrite_i = 1'b0;
        alu("fwd_memwb", 2'b10, F_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd201);
        EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd0; MEMWB_RDaddr_i = 5'd0; RS1addr_i = 5'd0;
        alu("fwd_x0", 2'b10, F_ADD, 1'b0, 32'd9, 32'd1, 32'd0, 32'd10);
        clear_inputs();

        // RS2 forwarding reaches store data even when IMM feeds the ALU
        RS2addr_i = 5'd5; MEMWB_RegWrite_i = 1'b1; MEMWB_RDaddr_i = 5'd5; MEMWB_data_i = 32'h55;
        alu("alusrc_imm", 2'b00, F_ADD, 1'b1, 32'd2, 32'd9, 32'd3, 32'd5);
        check("fwd_rs2data", RS2data_o, 32'h55);
        alu("fwd_rs2_alu", 2'b10, F_ADD, 1'b0, 32'd2, 32'd9, 32'd3, 32'h57);
        clear_inputs();

        alu("sub", 2'b10, F_SUB, 1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
        alu("aluop_sub", 2'b01, F_ADD, 1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
        alu("and", 2'b10, F_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_0004, 32'd0, 32'h00F0_0004);
        alu("or",  2'b10, F_OR,  1'b0, 32'hF0F0_1234, 32'h0FF0_0004, 32'd0, 32'hFFF0_1234);
        alu("xor", 2'b10, F_XOR, 1'b0, 32'hF0F0_1234, 32'h0FF0_0004, 32'd0, 32'hFF00_1230);
        alu("sll", 2'b10, F_SLL, 1'b0, 32'hF0F0_1234, 32'h0FF0_0004, 32'd0, 32'h0F01_2340);
        alu("srai", 2'b11, F_SRAI, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000);
        alu("addi", 2'b11, F_ADD, 1'b1, 32'd40, 32'd0, 32'hFFFF_FFFF, 32'd39);
        alu("andi", 2'b11, 10'b0000000_111, 1'b1, 32'hFF, 32'd0, 32'h0F, 32'h0F);
        alu("ori",  2'b11, 10'b0000000_110, 1'b1, 32'hF0, 32'd0, 32'h0F, 32'hFF);
        alu("undef_r", 2'b10, 10'b0000000_010, 1'b0, 32'd7, 32'd8, 32'd0, 32'd0);
        check("undef_valid", {31'd0, valid_o}, 32'd1);
        alu("undef_srli", 2'b11, 10'b0000000_101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0);

        // valid_i=0 registers a bubble whatever the other inputs hold
        drive(2'b10, F_MUL, 1'b0, 32'd6, 32'd7, 32'd0);
        valid_i = 1'b0;
        #1;
        check("bubble_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("bubble_valid", {31'd0, valid_o}, 32'd0);
        check("bubble_wb", {30'd0, WB_o}, 32'd0);
        check("bubble_res", ALUResult_o, 32'd0);
        check("bubble_rd", {27'd0, RDaddr_o}, 32'd0);
        tick();
        clear_inputs();

`ifdef EX_MUL_EN
        // RS1 comes from EX/MEM and that source is overwritten mid-stall
        EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd1; EXMEM_data_i = 32'hFFFF_FFFF;
        run_mul("mul_fwd", 32'd0, 32'd3, 32'hFFFF_FFFD);
        clear_inputs();
        run_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
        run_mul("mul_2x8", 32'd2, 32'd8, 32'd16);
        alu("after_mul_add", 2'b10, F_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 32'd3);
        check("after_mul_stall", {31'd0, stall_o}, 32'd0);

        // Reset in the middle of BUSY aborts the multiply
        drive(2'b10, F_MUL, 1'b0, 32'd5, 32'd5, 32'd0);
        for (int k = 0; k < 11; k++) tick();
        check("midrst_busy_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check("postrst_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("postrst_valid", {31'd0, valid_o}, 32'd0);
        check("postrst_stall2", {31'd0, stall_o}, 32'd0);
        check("postrst_res", ALUResult_o, 32'd0);
`else
        // Without the MUL unit the MUL encoding is undefined and single-cycle
        drive(2'b10, F_MUL, 1'b0, 32'd6, 32'd7, 32'd0);
        #1;
        check("nomul_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("nomul_res", ALUResult_o, 32'd0);
        check("nomul_valid", {31'd0, valid_o}, 32'd1);
        alu("nomul_next_add", 2'b10, F_ADD, 1'b0, 32'd6, 32'd7, 32'd0, 32'd13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs: operand forwarding, ALUSrc mux, ALU decode/execute, and an iterative multi-cycle MUL unit.
- Registers its results into the EX/MEM boundary. Generates a stall to freeze PC, IF/ID and ID/EX while a multiply is in flight.
- Sits between the ID/EX register and the data-memory stage of the 5-stage RISC-V core.

Parameters:
- XLEN, 32, datapath width; also the MUL iteration count.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
- WB_i  in  2  WB control {RegWrite, MemtoReg}, passed through
- MEM_i  in  1  MemWrite, passed through
- ALUSrc_i  in  1  1 selects IMM_i as operand B
- ALUOp_i  in  2  ALU class
- funct_i  in  10  {funct7, funct3}
- RS1_i, RS2_i, IMM_i  in  XLEN  register and immediate data
- RS1addr_i, RS2addr_i, RDaddr_i  in  5  register addresses
- EXMEM_RegWrite_i, MEMWB_RegWrite_i  in  1  forwarding source write enables
- EXMEM_RDaddr_i, MEMWB_RDaddr_i  in  5  forwarding destinations
- EXMEM_data_i, MEMWB_data_i  in  XLEN  forwarding data
- stall_o  out  1  combinational; freeze upstream stages this cycle
- valid_o  out  1  registered EX/MEM valid
- WB_o  out  2  registered
- MEM_o  out  1  registered
- ALUResult_o  out  XLEN  registered result
- RS2data_o  out  XLEN  registered forwarded RS2, used as store data
- RDaddr_o  out  5  registered

Behaviour:
- Reset: async on rst_i=1. All registered outputs are 0, FSM goes to IDLE, iteration counter 0. stall_o=0 while in reset.
- Forwarding, per operand: EX/MEM is used when EXMEM_RegWrite_i && EXMEM_RDaddr_i!=0 && addr match. Otherwise MEM/WB under the same rule. Otherwise the ID/EX data. EX/MEM has priority on a double match. Address 0 is never forwarded.
- Operand B is IMM_i if ALUSrc_i=1, else forwarded RS2. RS2data_o always takes forwarded RS2.
- ALU decode:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10 (R-type), by funct_i: 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_110 or, 0000000_100 xor, 0000000_001 sll (B[4:0]), 0000001_000 MUL.
  - ALUOp 11 (I-type), by funct3: 000 addi, 111 andi, 110 ori, 101 with funct7=0100000 srai (IMM[4:0], arithmetic).
  - Any undefined code gives result 0.
- Arithmetic wraps modulo 2^XLEN. MUL returns the low XLEN bits of the product; this is sign-agnostic.
- Non-MUL latency: 1 cycle. Result is visible on the outputs after the next rising edge. stall_o=0.
- MUL FSM:
  - IDLE: valid_i && MUL decode → stall_o=1 combinationally this cycle. At the edge, latch the forwarded operands, clear the accumulator and counter, go to BUSY. EX/MEM captures a bubble.
  - BUSY: one shift-add iteration per cycle. stall_o=1. EX/MEM captures a bubble each edge. After XLEN iterations go to DONE.
  - DONE: stall_o=0. EX/MEM captures the product with the instruction's WB/MEM/RDaddr, valid_o=1. Next state is IDLE.
- MUL timing: stall_o is high for XLEN+1 cycles. The result is registered XLEN+2 edges after the MUL first appears.
- Bubble output means valid_o=0, WB_o=0, MEM_o=0. ALUResult_o, RS2data_o and RDaddr_o are 0.
- Operands are latched at MUL start. Forwarding sources drain during the stall, and later changes on the forwarding inputs must not affect the product.
- DONE never re-triggers on the same instruction. A back-to-back MUL is detected afresh in IDLE on the following cycle.
- valid_i=0: a bubble is registered and no MUL starts, whatever funct_i holds.
- Reset mid-MUL: abort immediately, return to IDLE, drop the partial result, stall_o=0.

Optional Feature:
- EX_MUL_EN defined: MUL FSM and decode exist as described.
- Not defined: no FSM or accumulator. stall_o is tied 0. funct 0000001_000 decodes as undefined (result 0), single cycle.

Test Plan:
- Reset → all outputs 0 and stall_o=0. Assert rst_i in BUSY at iteration 10 → next cycle stall_o=0, valid_o=0.
- R-type add, RS1_i=5, RS2_i=7, no hazards → next edge ALUResult_o=12, valid_o=1, RDaddr_o matches.
- Forwarding: RS1addr_i=3, EXMEM_RDaddr_i=3 (data 100), MEMWB_RDaddr_i=3 (data 200), RS1_i=1, RS2_i=1, add → ALUResult_o=101. With EXMEM_RDaddr_i=0 and RS1addr_i=0, RS1_i=9 → uses 9.
- srai with RS1_i=0x80000000, IMM_i[4:0]=4 → 0xF8000000. sub 3-5 → 0xFFFFFFFE.
- MUL 0xFFFFFFFF×3 → stall_o high 33 cycles, 33 bubble edges, then ALUResult_o=0xFFFFFFFD, valid_o=1. Change EXMEM_data_i mid-stall → result unchanged.
- Back-to-back MUL 6×7 then MUL 2×8 → results 42 then 16, each preceded by a 33-cycle stall. Build without EX_MUL_EN → MUL gives 0 with no stall.
